// File: rtl/lock_corruption_monitor_pkg.sv
// Shared types and constants for the lock corruption monitor: FSM states,
// drain length and the popcount result width helper.
package lock_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int unsigned DRAIN_CYCLES = 2;

    function automatic int unsigned pc_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/lock_corruption_monitor_if.sv
// Sample stream between a locked/golden result source and the monitor.
interface lock_corruption_monitor_if #(
    parameter int unsigned DATA_W = 33
);
    logic              valid_i;
    logic [DATA_W-1:0] locked_i;
    logic [DATA_W-1:0] golden_i;
    logic              ready_o;

    modport master (output valid_i, output locked_i, output golden_i, input ready_o);
    modport slave  (input valid_i, input locked_i, input golden_i, output ready_o);
endinterface

// File: rtl/lock_popcount.sv
// Combinational population count built as a binary adder tree over a
// power-of-two padded leaf set (heap indexing: node k sums nodes 2k and 2k+1).
module lock_popcount
    import lock_mon_pkg::*;
#(
    parameter  int unsigned DATA_W = 33,
    localparam int unsigned PC_W   = pc_width(DATA_W)
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [PC_W-1:0]   count_o
);
    localparam int unsigned LEAVES = 1 << $clog2(DATA_W);

    logic [PC_W-1:0] node [1:2*LEAVES-1];

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < DATA_W) begin : g_bit
            assign node[LEAVES+i] = PC_W'(data_i[i]);
        end else begin : g_pad
            assign node[LEAVES+i] = '0;
        end
    end

    for (genvar k = 1; k < LEAVES; k++) begin : g_sum
        assign node[k] = node[2*k] + node[2*k+1];
    end

    assign count_o = node[1];

endmodule

// File: rtl/lock_corruption_monitor.sv
// Scores a locked netlist against golden results over a programmed number of
// samples: corrupted-sample count, total and worst-case Hamming distance.
module lock_corruption_monitor
    import lock_mon_pkg::*;
#(
    parameter  int unsigned DATA_W = 33,
    parameter  int unsigned CNT_W  = 32,
    parameter  int unsigned HD_W   = 40,
    localparam int unsigned PC_W   = pc_width(DATA_W)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [CNT_W-1:0]           sample_count_i,
    lock_corruption_monitor_if.slave   smp,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [CNT_W-1:0]           err_samples_o,
    output logic [HD_W-1:0]            hd_sum_o,
    output logic [PC_W-1:0]            max_hd_o
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [HD_W-1:0]   hd_q, hd_d;
    logic [PC_W-1:0]   max_q, max_d;
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_diff_q, s1_diff_d;
    logic [1:0]        drain_q, drain_d;

    logic              accept;
    logic [PC_W-1:0]   pc;
    logic [HD_W:0]     hd_ext;
    logic [CNT_W:0]    err_ext;

    assign accept = smp.valid_i && (state_q == RUN);

    lock_popcount #(.DATA_W(DATA_W)) u_popcount (
        .data_i  (s1_diff_q),
        .count_o (pc)
    );

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        acc_d      = acc_q;
        err_d      = err_q;
        hd_d       = hd_q;
        max_d      = max_q;
        drain_d    = drain_q;
        s1_valid_d = accept;
        s1_diff_d  = accept ? (smp.locked_i ^ smp.golden_i) : s1_diff_q;

        // One spare carry bit detects overflow so both counters stick at all-ones.
        hd_ext  = {1'b0, hd_q} + (HD_W+1)'(pc);
        err_ext = {1'b0, err_q} + (CNT_W+1)'(pc != '0);

        if (s1_valid_q) begin
            hd_d  = hd_ext[HD_W]   ? '1 : hd_ext[HD_W-1:0];
            err_d = err_ext[CNT_W] ? '1 : err_ext[CNT_W-1:0];
            if (pc > max_q) begin
                max_d = pc;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    target_d = sample_count_i;
                    acc_d    = '0;
                    err_d    = '0;
                    hd_d     = '0;
                    max_d    = '0;
                    state_d  = (sample_count_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    acc_d = acc_q + CNT_W'(1);
                    if (acc_q == target_q - CNT_W'(1)) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            target_q   <= '0;
            acc_q      <= '0;
            err_q      <= '0;
            hd_q       <= '0;
            max_q      <= '0;
            drain_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
            hd_q       <= hd_d;
            max_q      <= max_d;
            drain_q    <= drain_d;
            s1_valid_q <= s1_valid_d;
            s1_diff_q  <= s1_diff_d;
        end
    end

    assign smp.ready_o   = (state_q == RUN);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign err_samples_o = err_q;
    assign hd_sum_o      = hd_q;
    assign max_hd_o      = max_q;

endmodule
